spi_register_bank: RTL and testbench
====================================

Name: spi_register_bank

Overview:
- Register-file command decoder sitting directly downstream of spi_slave_interface, in the clk domain.
- Consumes the synchronized received word and new-data flag, and acknowledges each word via clear_new_data_flag.
- Decodes the first word of each frame as a command (read/write + start address); writes or reads subsequent words to/from an internal bank.
- Drives data_to_send back to the SPI slave and exposes a local read port plus write strobes to fabric logic.

Parameters:
- DATA_WIDTH, 16, word width; must match the upstream SPI slave.
- ADDR_WIDTH, 4, address bits; bank depth = 2**ADDR_WIDTH; ADDR_WIDTH < DATA_WIDTH.

Ports:
- clk  in  1  system clock; must run >= 4x sck.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- cs  in  1  raw SPI chip select, high = deselected; synchronized internally.
- new_data_flag  in  1  synced_new_data_flag from the SPI slave.
- data_received  in  DATA_WIDTH  synced_data_received from the SPI slave.
- clear_new_data_flag  out  1  acknowledge to the SPI slave.
- data_to_send  out  DATA_WIDTH  word loaded by the SPI slave at the next word boundary.
- wr_strobe  out  1  one-clk pulse per register write.
- wr_addr  out  ADDR_WIDTH  address of the current write; valid with wr_strobe.
- wr_data  out  DATA_WIDTH  data of the current write; valid with wr_strobe.
- local_addr  in  ADDR_WIDTH  fabric read address.
- local_rd_data  out  DATA_WIDTH  combinational read of bank[local_addr].
- frame_active  out  1  high while the FSM is in any state other than IDLE.

Behaviour:
- Reset (reset=0, async):
  - all bank entries, addr, and the write-mode bit are 0.
  - cs synchronizer flops are 1.
  - state = IDLE.
  - clear_new_data_flag, wr_strobe, frame_active are 0; data_to_send is 0.
- cs_s: cs passed through a 2-FF synchronizer. cs_s=1 forces state=IDLE from any state on the next clk and deasserts clear_new_data_flag. Bank contents are kept.
- Command word format:
  - bit DATA_WIDTH-1 = 1 means write, 0 means read.
  - bits ADDR_WIDTH-1:0 = start address.
  - all other bits are ignored.
- FSM states:
  - IDLE: cs_s=0 -> CMD.
  - CMD: on new_data_flag=1, latch the write bit and addr=data_received[ADDR_WIDTH-1:0]; set ret=DATA; -> ACK.
  - DATA, new_data_flag=1, write mode: bank[addr] <= data_received; wr_strobe=1 for one clk with wr_addr=addr and wr_data=data_received; addr advances; ret=DATA; -> ACK.
  - DATA, new_data_flag=1, read mode: received word discarded; addr advances; -> ACK.
  - ACK: clear_new_data_flag=1 (registered) while in ACK. When new_data_flag is sampled 0, deassert clear_new_data_flag and -> ret.
- A flag still high on ACK exit cannot occur; ACK leaves only after the flag is seen 0, so each word is processed exactly once.
- Address advance: addr+1 modulo 2**ADDR_WIDTH (15 -> 0 wraps silently).
- data_to_send is registered:
  - read mode in ACK/DATA: bank[addr], i.e. the post-command or post-advance address.
  - otherwise: 0.
  - It is updated within 2 clk of the flag being sampled, well before the next word boundary given the clk >= 4x sck rule.
  - For reads, bank[start] is returned in SPI word 2, bank[start+1] in word 3, and so on.
- Simultaneous fabric read and SPI write to the same entry: local_rd_data shows the old value that cycle and the new value the next cycle.
- Reset mid-operation: immediate return to reset values. Any partially processed word is dropped with no wr_strobe.

Optional Feature:
- Macro: SPI_REG_AUTOINC_EN.
- Defined: addr advances after every DATA word, as described above (burst access).
- Undefined:
  - addr stays fixed for the whole frame.
  - Repeated writes overwrite the same entry.
  - Repeated reads return the same entry.

Test Plan:
- Reset: drive reset=0 mid-traffic -> clear_new_data_flag=0, wr_strobe=0, data_to_send=0x0000; local_rd_data=0x0000 for all 16 addresses.
- Burst write: cs=0, words 0x8003, 0xBEEF, 0x1234 -> two wr_strobe pulses (addr 3 data 0xBEEF, addr 4 data 0x1234); local_addr=3 gives 0xBEEF, 4 gives 0x1234; each word acked exactly once.
- Burst read after the burst write: words 0x0003, 0x0000, 0x0000 -> data_to_send=0xBEEF before word 2 and 0x1234 before word 3; no wr_strobe.
- Wrap: words 0x800F, 0x00AA, 0x00BB -> bank[15]=0x00AA, bank[0]=0x00BB.
- cs abort: cs rises after the command 0x8005 is acked, then a new frame of 0x0005 -> FSM passes through IDLE; the second frame's first word is decoded as a command; bank[5] is unchanged.
- Autoinc off (macro undefined): words 0x8002, 0x1111, 0x2222 -> bank[2]=0x2222 and bank[3] is unchanged.

Source files
------------

// File: rtl/spi_register_bank.sv
// Command decoder and register bank behind the SPI slave: first word per frame is a command, later words are burst data.
// Optional SPI_REG_AUTOINC_EN: advance the address after every data word (otherwise the address stays fixed per frame).
module spi_register_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  new_data_flag,
  input  logic [DATA_WIDTH-1:0] data_received,
  output logic                  clear_new_data_flag,
  output logic [DATA_WIDTH-1:0] data_to_send,
  output logic                  wr_strobe,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] local_addr,
  output logic [DATA_WIDTH-1:0] local_rd_data,
  output logic                  frame_active
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef SPI_REG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CMD, DATA, ACK} state_t;

  state_t                           state, ret;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] bank;
  logic [ADDR_WIDTH-1:0]            addr, next_addr;
  logic                             wr_mode;
  logic                             cs_q, cs_s;

  assign next_addr     = AUTOINC ? addr + ADDR_WIDTH'(1) : addr;
  assign local_rd_data = bank[local_addr];
  assign frame_active  = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      ret                 <= IDLE;
      bank                <= '0;
      addr                <= '0;
      wr_mode             <= 1'b0;
      cs_q                <= 1'b1;
      cs_s                <= 1'b1;
      clear_new_data_flag <= 1'b0;
      data_to_send        <= '0;
      wr_strobe           <= 1'b0;
      wr_addr             <= '0;
      wr_data             <= '0;
    end else begin
      cs_q      <= cs;
      cs_s      <= cs_q;
      wr_strobe <= 1'b0;
      // Reads follow the current address one clk after it settles, long before the next SPI word boundary.
      data_to_send <= (!wr_mode && (state == ACK || state == DATA)) ? bank[addr] : '0;
      if (cs_s) begin
        state               <= IDLE;
        clear_new_data_flag <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= CMD;
          CMD: if (new_data_flag) begin
            wr_mode             <= data_received[DATA_WIDTH-1];
            addr                <= data_received[ADDR_WIDTH-1:0];
            ret                 <= DATA;
            clear_new_data_flag <= 1'b1;
            state               <= ACK;
          end
          DATA: if (new_data_flag) begin
            if (wr_mode) begin
              bank[addr] <= data_received;
              wr_strobe  <= 1'b1;
              wr_addr    <= addr;
              wr_data    <= data_received;
            end
            addr                <= next_addr;
            ret                 <= DATA;
            clear_new_data_flag <= 1'b1;
            state               <= ACK;
          end
          // Hold the ack until the slave drops its flag so each word is consumed exactly once.
          ACK: if (!new_data_flag) begin
            clear_new_data_flag <= 1'b0;
            state               <= ret;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_register_bank.sv
// Directed bench for spi_register_bank: a small SPI-slave handshake model drives words, outputs checked against hand-computed values.
module tb_spi_register_bank;
`ifdef SPI_REG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b0, cs = 1'b1, new_data_flag = 1'b0;
  logic [15:0] data_received = '0;
  logic        clear_new_data_flag, wr_strobe, frame_active;
  logic [15:0] data_to_send, wr_data, local_rd_data;
  logic [3:0]  wr_addr, local_addr = '0;

  int checks = 0, failures = 0, acks = 0;
  logic clr_d = 1'b0;
  logic [3:0]  wq_addr[$];
  logic [15:0] wq_data[$];

  spi_register_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .cs(cs), .new_data_flag(new_data_flag),
    .data_received(data_received), .clear_new_data_flag(clear_new_data_flag),
    .data_to_send(data_to_send), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .local_addr(local_addr), .local_rd_data(local_rd_data),
    .frame_active(frame_active)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (clear_new_data_flag && !clr_d) acks++;
    clr_d = clear_new_data_flag;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input logic lvl);
    int k = 0;
    while (clear_new_data_flag !== lvl && k < 50) begin tick(1); k++; end
    checks++;
    if (clear_new_data_flag !== lvl) begin
      failures++;
      $display("FAIL ack_wait: clear_new_data_flag=%b required %b within 50 clk", clear_new_data_flag, lvl);
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    wait_clear(1'b0);
    data_received = w;
    new_data_flag = 1'b1;
    wait_clear(1'b1);
    new_data_flag = 1'b0;
    wait_clear(1'b0);
  endtask

  task automatic start_frame();
    cs = 1'b0;
    tick(4);
  endtask

  task automatic end_frame();
    cs = 1'b1;
    tick(4);
  endtask

  task automatic peek(input logic [3:0] a, output logic [15:0] d);
    local_addr = a;
    #1;
    d = local_rd_data;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    int nstb;
    checks++;
    if ({clear_new_data_flag, wr_strobe, frame_active} !== 3'b000 || data_to_send !== 16'h0000) begin
      failures++;
      $display("FAIL reset_outputs: clr/stb/act=%b%b%b dts=%h required 000 0000",
               clear_new_data_flag, wr_strobe, frame_active, data_to_send);
    end
    reset = 1'b1;
    tick(2);
    start_frame();
    send_word(16'h8001);
    send_word(16'h7777);
    peek(4'd1, d);
    checks++;
    if (d !== 16'h7777) begin failures++; $display("FAIL pre_reset_write: bank[1]=%h required 7777", d); end
    nstb = wq_addr.size();
    // Word in flight when reset lands must be dropped.
    data_received = 16'h5555;
    new_data_flag = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({clear_new_data_flag, wr_strobe, frame_active} !== 3'b000 || data_to_send !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_outputs: clr/stb/act=%b%b%b dts=%h required 000 0000",
               clear_new_data_flag, wr_strobe, frame_active, data_to_send);
    end
    tick(2);
    checks++;
    if (wq_addr.size() !== nstb) begin
      failures++; $display("FAIL midreset_strobe: strobes=%0d required %0d", wq_addr.size(), nstb);
    end
    for (int i = 0; i < 16; i++) begin
      peek(4'(i), d);
      checks++;
      if (d !== 16'h0000) begin failures++; $display("FAIL reset_bank[%0d]: %h required 0000", i, d); end
    end
    new_data_flag = 1'b0;
    cs = 1'b1;
    tick(1);
    reset = 1'b1;
    tick(3);
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic test_burst_write();
    logic [15:0] d;
    int a0 = acks;
    logic [3:0] a2 = AUTOINC ? 4'd4 : 4'd3;
    start_frame();
    checks++;
    if (frame_active !== 1'b1) begin failures++; $display("FAIL bw_active: frame_active=%b required 1", frame_active); end
    send_word(16'h8003);
    send_word(16'hBEEF);
    checks++;
    if (data_to_send !== 16'h0000) begin failures++; $display("FAIL bw_dts: data_to_send=%h required 0000", data_to_send); end
    send_word(16'h1234);
    end_frame();
    checks++;
    if (acks - a0 !== 3) begin failures++; $display("FAIL bw_acks: acks=%0d required 3", acks - a0); end
    checks++;
    if (wq_addr.size() !== 2) begin
      failures++; $display("FAIL bw_strobes: count=%0d required 2", wq_addr.size());
    end else begin
      checks++;
      if (wq_addr[0] !== 4'd3 || wq_data[0] !== 16'hBEEF || wq_addr[1] !== a2 || wq_data[1] !== 16'h1234) begin
        failures++;
        $display("FAIL bw_strobe_vals: %h:%h %h:%h required 3:beef %h:1234",
                 wq_addr[0], wq_data[0], wq_addr[1], wq_data[1], a2);
      end
    end
    peek(4'd3, d);
    checks++;
    if (d !== (AUTOINC ? 16'hBEEF : 16'h1234)) begin failures++; $display("FAIL bw_bank3: %h", d); end
    peek(4'd4, d);
    checks++;
    if (d !== (AUTOINC ? 16'h1234 : 16'h0000)) begin failures++; $display("FAIL bw_bank4: %h", d); end
    checks++;
    if (frame_active !== 1'b0) begin failures++; $display("FAIL bw_idle: frame_active=%b required 0", frame_active); end
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic test_burst_read();
    start_frame();
    send_word(16'h0003);
    checks++;
    if (data_to_send !== (AUTOINC ? 16'hBEEF : 16'h1234)) begin
      failures++; $display("FAIL br_word2: data_to_send=%h", data_to_send);
    end
    send_word(16'h0000);
    checks++;
    if (data_to_send !== 16'h1234) begin
      failures++; $display("FAIL br_word3: data_to_send=%h required 1234", data_to_send);
    end
    send_word(16'h0000);
    end_frame();
    checks++;
    if (wq_addr.size() !== 0) begin failures++; $display("FAIL br_nostrobe: strobes=%0d required 0", wq_addr.size()); end
    checks++;
    if (data_to_send !== 16'h0000) begin failures++; $display("FAIL br_idle_dts: %h required 0000", data_to_send); end
  endtask

  task automatic test_wrap();
    logic [15:0] d;
    start_frame();
    send_word(16'h800F);
    send_word(16'h00AA);
    send_word(16'h00BB);
    end_frame();
    peek(4'd15, d);
    checks++;
    if (d !== (AUTOINC ? 16'h00AA : 16'h00BB)) begin failures++; $display("FAIL wrap_bank15: %h", d); end
    peek(4'd0, d);
    checks++;
    if (d !== (AUTOINC ? 16'h00BB : 16'h0000)) begin failures++; $display("FAIL wrap_bank0: %h", d); end
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic test_cs_abort();
    logic [15:0] d;
    start_frame();
    send_word(16'h8005);
    end_frame();
    checks++;
    if (frame_active !== 1'b0) begin failures++; $display("FAIL abort_idle: frame_active=%b required 0", frame_active); end
    start_frame();
    send_word(16'h0005);
    send_word(16'h0000);
    end_frame();
    checks++;
    if (wq_addr.size() !== 0) begin failures++; $display("FAIL abort_nostrobe: strobes=%0d required 0", wq_addr.size()); end
    peek(4'd5, d);
    checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL abort_bank5: %h required 0000", d); end
  endtask

  task automatic test_autoinc_off();
    logic [15:0] d;
    start_frame();
    send_word(16'h8002);
    send_word(16'h1111);
    send_word(16'h2222);
    end_frame();
    peek(4'd2, d);
    checks++;
    if (d !== (AUTOINC ? 16'h1111 : 16'h2222)) begin failures++; $display("FAIL fixed_bank2: %h", d); end
    peek(4'd3, d);
    checks++;
    if (d !== (AUTOINC ? 16'h2222 : 16'h1234)) begin failures++; $display("FAIL fixed_bank3: %h", d); end
  endtask

  initial begin
    tick(3);
    test_reset();
    test_burst_write();
    test_burst_read();
    test_wrap();
    test_cs_abort();
    test_autoinc_off();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
